ucore_axi_rd_arb: RTL
=====================

# ucore_axi_rd_arb

Shares the single AXI4 read address/data channel pair (AR/R) of `ucore_main` between NREQ internal requesters (e.g. fetch, load), issuing single-beat 128-bit reads with one transaction outstanding. Requesters see a simple valid/ready request and a one-cycle response pulse. The block sits between the core's memory clients and the `m_axi_ar*` / `m_axi_r*` ports.

## Interface
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 28, AXI address width
- DATA_W, 128, AXI data width
- ID_W, 4, AXI ID width; must satisfy 2^ID_W >= NREQ
- clk  in  1  single clock; all logic on its rising edge
- aresetn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester read request
- req_addr  in  NREQ*ADDR_W  packed request addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_ready  out  NREQ  one-hot accept; request i taken when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse
- rsp_data  out  DATA_W  read data, valid with any rsp_valid bit
- rsp_err  out  1  error flag, valid with any rsp_valid bit
- m_axi_arvalid/arready/araddr/arid/arlen/arsize/arburst/arlock/arcache/arprot/arqos  AXI4 AR, standard directions and widths (addr ADDR_W, id ID_W)
- m_axi_rvalid/rready/rdata/rid/rresp/rlast  AXI4 R, standard directions and widths (data DATA_W, id ID_W)

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any req_valid, arbiter picks grant g; req_ready[g]=1 combinationally this cycle; latch g and req_addr[g]; go to ADDR. Otherwise stay; req_ready all 0 outside IDLE.
- ADDR: m_axi_arvalid=1, araddr=latched addr, arid=g (zero-extended); arvalid and all AR fields held stable until arready. On arready go to DATA.
- DATA: m_axi_rready=1. On rvalid: capture rdata into rsp_data; rsp_err = rresp[1] | (rid != g) | !rlast; go to IDLE; rsp_valid[g] pulses the following cycle.
- Constant AR fields: arlen=0, arsize=log2(DATA_W/8) (4 for 128), arburst=INCR (01), arlock=0, arcache=0011, arprot=000, arqos=0.
- Round-robin: pointer holds last granted index; search starts at pointer+1 mod NREQ; pointer updates only on acceptance.
- req_valid may drop without acceptance; no requirement on requester stability before acceptance.
- rsp_data holds its value until the next capture.

## Timing
- Reset: state=IDLE, pointer=NREQ-1 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, arvalid=0, rready=0, araddr=0, arid=0.
- Accept at cycle T -> arvalid from T+1; arready at T+1 -> rready from T+2; rvalid at T+2 -> rsp_valid at T+3 and next accept possible at T+3. Minimum 3 cycles request-to-response, one request per 3 cycles throughput.
- arready stalls extend ADDR; rvalid stalls extend DATA; no timeout.
- rsp_valid pulse and a new acceptance may coincide (same cycle).
- aresetn asserted mid-transaction: immediately return all state/outputs to reset values; in-flight AXI transaction abandoned (interconnect reset together with the core).

## Configuration
- UCORE_RD_ARB_FIXED_PRI_EN defined: fixed priority, lowest index wins; pointer register not built.
- Not defined: round-robin as in Operation.

## Structure
- Package ucore_axi_pkg: AXI burst/size/cache/prot constants, response codes (OKAY/EXOKAY/SLVERR/DECERR), arbiter FSM state enum.
- One sub-module: ucore_rr_arb (NREQ requests + pointer -> one-hot grant, index, any-valid); fixed-priority mode selected inside it by the macro.

## Test plan
- Single request: req_valid[0], addr 0x0001000, AR/R ready immediately, rdata 0xA5..A5 -> araddr 0x0001000, arid 0, arlen 0, arsize 4, arburst 01; rsp_valid[0] 3 cycles after accept, rsp_data 0xA5..A5, rsp_err 0.
- Both requesters held valid continuously, 6 transactions -> grants 0,1,0,1,0,1 (round-robin); with macro -> 0 six times.
- arready delayed 5 cycles, rvalid delayed 4 -> AR fields stable throughout ADDR; rsp_valid exactly one cycle after R handshake; no second acceptance before it.
- rresp=SLVERR (10), and separately rid=3 for grant 1 -> rsp_err=1 with rsp_valid[g].
- aresetn low during DATA -> all outputs at reset values within the same cycle; after release requester 0 granted first.
- req_valid[1] pulsed one cycle while state=ADDR -> never accepted, no response for requester 1.

Source files
------------

// File: rtl/ucore_axi_pkg.sv
// Shared AXI4 constants and arbiter FSM state type for the ucore read-channel arbiter.
package ucore_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } rd_arb_state_e;

  // AxSIZE encoding for a full-width beat of the given byte count.
  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/ucore_rr_arb.sv
// Request arbiter: round-robin starting after ptr_i, or fixed lowest-index priority
// when UCORE_RD_ARB_FIXED_PRI_EN is defined (ptr_i then ignored).
module ucore_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;

`ifdef UCORE_RD_ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Descending scan so the last hit, the lowest index, wins.
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  // Scan starts one past the last winner, wrapping, so the last winner is tried last.
  always_comb begin
    int cand;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_i) + i) % NREQ;
      if (!found && req_i[cand]) begin
        idx_o = IDX_W'(cand);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[idx_o] = 1'b1;
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ucore_axi_rd_arb.sv
// Shares one AXI4 AR/R channel pair among NREQ requesters, single-beat reads, one outstanding.
// Define UCORE_RD_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module ucore_axi_rd_arb
  import ucore_axi_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [ID_W-1:0]        m_axi_arid,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [3:0]             m_axi_arcache,
  output logic [2:0]             m_axi_arprot,
  output logic [3:0]             m_axi_arqos,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic [ID_W-1:0]        m_axi_rid,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  rd_arb_state_e     state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [IDX_W-1:0]  arb_ptr;
  logic              arb_any;
  logic              accept;

  ucore_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Gated by aresetn so no requester sees a handshake while the block is held in reset.
  assign accept    = (state_q == ARB_IDLE) && arb_any && aresetn;
  assign req_ready = accept ? arb_gnt : '0;

`ifdef UCORE_RD_ARB_FIXED_PRI_EN
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)    ptr_q <= IDX_W'(NREQ - 1);
    else if (accept) ptr_q <= arb_idx;
  end

  assign arb_ptr = ptr_q;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          gnt_d   = arb_idx;
          addr_d  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (m_axi_arready) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        if (m_axi_rvalid) begin
          rsp_data_d  = m_axi_rdata;
          // A misrouted or multi-beat answer is as unusable as a slave error.
          rsp_err_d   = m_axi_rresp[1] | (m_axi_rid != ID_W'(gnt_q)) | ~m_axi_rlast;
          rsp_valid_d = NREQ'(1) << gnt_q;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  assign m_axi_arvalid = (state_q == ARB_ADDR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = ID_W'(gnt_q);
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = axi_size(DATA_W / 8);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_BUF_MOD;
  assign m_axi_arprot  = AXI_PROT_DEFAULT;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_rready  = (state_q == ARB_DATA);

  // EXOKAY vs OKAY is irrelevant for plain reads; only rresp[1] flags an error.
  logic unused_rresp;
  assign unused_rresp = m_axi_rresp[0];

endmodule
